// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: groups the requester handshake, the UART TX core handshake and
// the arbiter status lines. The arbiter connects through the slave modport; the
// environment (producers plus UART core) connects through the master modport.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [IDX_W-1:0]     grant_id;
    logic                 arb_busy;
    logic                 err_tmo;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, arb_busy, err_tmo
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, arb_busy, err_tmo
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART TX core between NUM_REQ
// byte producers. One byte is accepted at a time, launched with a one-cycle
// tx_start, and the next arbitration waits until the core's busy has risen and
// fallen again. A missing busy rise is reported on err_tmo and the byte dropped.
// Optional feature macro UART_ARB_LOCK_EN: keeps the grant on one requester
// until it delivers a byte with req_last set (message lock).
module uart_tx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int START_TMO = 15
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_arb_if.slave bus_if
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         txData_q, txData_d;
    logic [IDX_W-1:0]   grantId_q, grantId_d;
    logic [IDX_W-1:0]   rrLast_q, rrLast_d;
    logic [7:0]         tmoCnt_q, tmoCnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               winValid;
    logic [IDX_W-1:0]   winIdx;
    logic [7:0]         winData;
    logic [NUM_REQ-1:0] readyVec;
    logic               txStart;
    logic               errTmo;
    int                 cand;
    logic [IDX_W-1:0]   candIdx;

`ifdef UART_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lockId_q, lockId_d;
`else
    logic               unused_reqLast;
    assign unused_reqLast = ^bus_if.req_last;
`endif

    // Eligible requesters: everyone that is valid, narrowed to the lock owner while a message is in progress
    always_comb begin
        eligible = bus_if.req_valid;
`ifdef UART_ARB_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                eligible[i] = bus_if.req_valid[i] && (lockId_q == IDX_W'(i));
            end
        end
`endif
    end

    // Round-robin search: first eligible index starting just after the last served one, wrapping around
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rrLast_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDX_W'(cand);
            if (!winValid && eligible[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Byte mux: only the winner's lane is ever routed towards the data register
    always_comb begin
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == IDX_W'(i)) begin
                winData = bus_if.req_data[8*i +: 8];
            end
        end
    end

    // Next-state and output decode for the accept / launch / wait-busy sequence
    always_comb begin
        state_d   = state_q;
        txData_d  = txData_q;
        grantId_d = grantId_q;
        rrLast_d  = rrLast_q;
        tmoCnt_d  = tmoCnt_q;
        readyVec  = '0;
        txStart   = 1'b0;
        errTmo    = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d    = lock_q;
        lockId_d  = lockId_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (winValid && !rst) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        readyVec[i] = (winIdx == IDX_W'(i));
                    end
                    txData_d  = winData;
                    grantId_d = winIdx;
`ifdef UART_ARB_LOCK_EN
                    if (bus_if.req_last[winIdx]) begin
                        lock_d   = 1'b0;
                        rrLast_d = winIdx;
                    end else begin
                        lock_d   = 1'b1;
                        lockId_d = winIdx;
                    end
`else
                    rrLast_d  = winIdx;
`endif
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                txStart  = 1'b1;
                tmoCnt_d = 8'(START_TMO);
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus_if.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmoCnt_q == 8'd0) begin
                    errTmo  = 1'b1;
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d   = 1'b0;
                    rrLast_d = grantId_q;
`endif
                end else begin
                    tmoCnt_d = tmoCnt_q - 8'd1;
                end
            end
            WAIT_LO: begin
                // Frame length depends on the baud rate, so no timeout here
                if (!bus_if.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset leaves requester 0 as the first in line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            txData_q  <= '0;
            grantId_q <= '0;
            rrLast_q  <= IDX_W'(NUM_REQ - 1);
            tmoCnt_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lockId_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            txData_q  <= txData_d;
            grantId_q <= grantId_d;
            rrLast_q  <= rrLast_d;
            tmoCnt_q  <= tmoCnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= lock_d;
            lockId_q  <= lockId_d;
`endif
        end
    end

    assign bus_if.req_ready = readyVec;
    assign bus_if.tx_data   = txData_q;
    assign bus_if.tx_start  = txStart;
    assign bus_if.grant_id  = grantId_q;
    assign bus_if.arb_busy  = (state_q != IDLE);
    assign bus_if.err_tmo   = errTmo;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb. Requester and UART core
// models run inside one tick task; expected grants/bytes go into a scoreboard
// queue when stimulus is set up and are compared at every tx_start pulse.
module tb_uart_tx_arb;
    localparam int NUM_REQ   = 4;
    localparam int IDX_W     = 2;
    localparam int START_TMO = 15;

    typedef struct {
        logic [IDX_W-1:0] id;
        logic [7:0]       data;
    } exp_t;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [31:0]        data;
        logic [NUM_REQ-1:0] expReady;
        logic [IDX_W-1:0]   expGrant;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    uart_tx_arb_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) busIf ();

    uart_tx_arb #(
        .NUM_REQ  (NUM_REQ),
        .IDX_W    (IDX_W),
        .START_TMO(START_TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(busIf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycleNum = 0;
    int          reqRem[NUM_REQ];
    int          reqSent[NUM_REQ];
    logic [7:0]  reqBase[NUM_REQ];
    bit          lastMode = 1'b0;
    exp_t        expQ[$];
    int          busyCnt = 0;
    int          busyLen = 4;
    int          ignoreStarts = 0;
    bit          heldValid = 1'b0;
    logic [7:0]  heldByte = '0;
    bit          checkReady = 1'b0;
    logic [NUM_REQ-1:0] expReady = '0;
    string       readyName = "";
    int          lastStartCycle = 0;
    int          errCount = 0;
    int          lastErrGap = -1;
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic bit allDone();
        bit d = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqRem[i] != 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic driveReqs();
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        logic [8*NUM_REQ-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i]         = (reqRem[i] != 0);
            l[i]         = lastMode ? (reqRem[i] == 1) : 1'b1;
            d[8*i +: 8]  = reqBase[i] + 8'(reqSent[i] * 16);
        end
        busIf.req_valid = v;
        busIf.req_last  = l;
        busIf.req_data  = d;
    endtask

    task automatic clearReqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            reqRem[i]  = 0;
            reqSent[i] = 0;
            reqBase[i] = 8'h00;
        end
        driveReqs();
    endtask

    // One clock: sample and check at negedge, then update requester and core models after posedge
    task automatic tick();
        logic [NUM_REQ-1:0] readyS;
        logic               startS;
        logic               rstS;
        exp_t               e;
        @(negedge clk);
        readyS = busIf.req_ready;
        startS = busIf.tx_start;
        rstS   = rst;
        if (checkReady) begin
            checkOutput(readyName, 32'(readyS), 32'(expReady));
            checkReady = 1'b0;
        end
        if (busIf.arb_busy) begin
            checkOutput("ready_outside_idle", 32'(readyS), 32'd0);
        end
        if (startS) begin
            checkOutput("start_overlaps_busy", 32'(busIf.tx_busy), 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start actual=1 required=0");
                heldValid = 1'b0;
            end else begin
                e = expQ.pop_front();
                checkOutput("grant_id", 32'(busIf.grant_id), 32'(e.id));
                checkOutput("tx_data", 32'(busIf.tx_data), 32'(e.data));
                heldValid = 1'b1;
                heldByte  = e.data;
            end
            lastStartCycle = cycleNum;
        end else if (heldValid) begin
            if (!busIf.arb_busy) begin
                heldValid = 1'b0;
            end else begin
                checkOutput("tx_data_hold", 32'(busIf.tx_data), 32'(heldByte));
            end
        end
        if (busIf.err_tmo) begin
            errCount++;
            lastErrGap = cycleNum - lastStartCycle;
        end
        @(posedge clk);
        #1;
        cycleNum++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (readyS[i] && !rstS) begin
                reqRem[i]--;
                reqSent[i]++;
            end
        end
        if (rstS) begin
            busyCnt = 0;
        end else begin
            if (busyCnt > 0) busyCnt--;
            if (startS) begin
                if (ignoreStarts > 0) ignoreStarts--;
                else busyCnt = busyLen;
            end
        end
        busIf.tx_busy = (busyCnt != 0);
        driveReqs();
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        bit done = 1'b0;
        for (int n = 0; n < maxCycles && !done; n++) begin
            tick();
            done = (expQ.size() == 0) && !busIf.arb_busy && allDone();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_timeout actual=busy required=idle_within_%0d", name, maxCycles);
            expQ.delete();
            heldValid = 1'b0;
            clearReqs();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(busIf.req_ready), 32'd0);
        checkOutput({tag, "_tx_start"},  32'(busIf.tx_start),  32'd0);
        checkOutput({tag, "_tx_data"},   32'(busIf.tx_data),   32'h00);
        checkOutput({tag, "_grant_id"},  32'(busIf.grant_id),  32'd0);
        checkOutput({tag, "_arb_busy"},  32'(busIf.arb_busy),  32'd0);
        checkOutput({tag, "_err_tmo"},   32'(busIf.err_tmo),   32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        expQ.delete();
        heldValid = 1'b0;
        clearReqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Applies one table vector as a single-byte round, then lets the frame drain
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqRem[i]  = v.valid[i] ? 1 : 0;
            reqSent[i] = 0;
            reqBase[i] = v.data[8*i +: 8];
        end
        e.id   = v.expGrant;
        e.data = v.data[8*v.expGrant +: 8];
        expQ.push_back(e);
        expReady   = v.expReady;
        readyName  = name;
        checkReady = 1'b1;
        driveReqs();
        tick();
        clearReqs();
        waitIdle(name, 200);
    endtask

    task automatic pushExp(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = IDX_W'(id);
        e.data = data;
        expQ.push_back(e);
    endtask

    // Safety net in case a bounded wait itself never returns
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        vecs[0] = '{4'b0001, 32'h000000D3, 4'b0001, 2'd0};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b0010, 2'd1};
        vecs[2] = '{4'b1001, 32'h9A000091, 4'b1000, 2'd3};
        vecs[3] = '{4'b1001, 32'h9B000092, 4'b0001, 2'd0};
        vecs[4] = '{4'b0100, 32'h00C40000, 4'b0100, 2'd2};
        vecs[5] = '{4'b0011, 32'h0000B6B5, 4'b0001, 2'd0};
        vecs[6] = '{4'b1100, 32'hE8E70000, 4'b0100, 2'd2};
        vecs[7] = '{4'b0010, 32'h0000F200, 4'b0010, 2'd1};

        rst = 1'b1;
        busIf.tx_busy = 1'b0;
        clearReqs();

        // Reset values, with every requester valid while rst is held
        for (int i = 0; i < NUM_REQ; i++) reqRem[i] = 1;
        driveReqs();
        tick();
        tick();
        checkResetOutputs("rst_held");
        clearReqs();
        rst = 1'b0;
        tick();
        checkResetOutputs("post_rst");

        // Table vectors: single-byte rounds exercising the round-robin search
        busyLen = 20;
        applyStimulus(vecs[0], "vec0_single_D3");
        busyLen = 3;
        for (int n = 1; n < 8; n++) begin
            applyStimulus(vecs[n], $sformatf("vec%0d_ready", n));
        end

        // All four valid continuously: grant order 0,1,2,3,0
        doReset();
        busyLen = 20;
        reqRem[0] = 2; reqRem[1] = 1; reqRem[2] = 1; reqRem[3] = 1;
        reqBase[0] = 8'hA0; reqBase[1] = 8'hA1; reqBase[2] = 8'hA2; reqBase[3] = 8'hA3;
        pushExp(0, 8'hA0);
        pushExp(1, 8'hA1);
        pushExp(2, 8'hA2);
        pushExp(3, 8'hA3);
        pushExp(0, 8'hB0);
        driveReqs();
        waitIdle("rr_continuous", 600);

        // Core ignores the first start: timeout then the next requester is served
        doReset();
        busyLen = 4;
        ignoreStarts = 1;
        errCount = 0;
        lastErrGap = -1;
        reqRem[0] = 1; reqBase[0] = 8'h11;
        reqRem[1] = 1; reqBase[1] = 8'h22;
        pushExp(0, 8'h11);
        pushExp(1, 8'h22);
        driveReqs();
        waitIdle("timeout_seq", 200);
        checkOutput("tmo_pulse_count", 32'(errCount), 32'd1);
        checkOutput("tmo_gap_cycles", 32'(lastErrGap), 32'(START_TMO + 1));
        ignoreStarts = 0;

        // Reset in the middle of a frame, then requester 0 wins first
        doReset();
        busyLen = 20;
        reqRem[2] = 1; reqBase[2] = 8'h77;
        pushExp(2, 8'h77);
        driveReqs();
        for (int n = 0; n < 6; n++) tick();
        checkOutput("midrst_in_frame_busy", 32'(busIf.arb_busy), 32'd1);
        checkOutput("midrst_core_busy", 32'(busIf.tx_busy), 32'd1);
        rst = 1'b1;
        tick();
        checkResetOutputs("midrst");
        rst = 1'b0;
        heldValid = 1'b0;
        busyLen = 3;
        applyStimulus('{4'b1111, 32'h5D5C5B5A, 4'b0001, 2'd0}, "midrst_first_grant");

        // Message from requester 2 while requester 0 is also valid
        doReset();
        busyLen = 6;
        applyStimulus('{4'b0010, 32'h00005A00, 4'b0010, 2'd1}, "lock_prep");
        lastMode = 1'b1;
        reqRem[2] = 3; reqBase[2] = 8'hC0;
        reqRem[0] = 2; reqBase[0] = 8'h50;
`ifdef UART_ARB_LOCK_EN
        pushExp(2, 8'hC0);
        pushExp(2, 8'hD0);
        pushExp(2, 8'hE0);
        pushExp(0, 8'h50);
        pushExp(0, 8'h60);
`else
        pushExp(2, 8'hC0);
        pushExp(0, 8'h50);
        pushExp(2, 8'hD0);
        pushExp(0, 8'h60);
        pushExp(2, 8'hE0);
`endif
        driveReqs();
        waitIdle("message_order", 400);
        lastMode = 1'b0;
        clearReqs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
